// File: rtl/fib_sched_pkg.sv
// Shared types and constants for the Fibonacci job scheduler: FSM state, error result, index-range helper.
// No logic of its own; no latency or backpressure.
package fib_sched_pkg;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  localparam logic [63:0] FIB_ERR_VALUE = '1;

  // Largest n with F(n) < 2**width, where F(0)=0 and F(1)=1.
  function automatic int fib_max_n(input int width);
    logic [64:0] a;
    logic [64:0] b;
    logic [64:0] t;
    logic [64:0] lim;
    int n;
    a = 65'd0;
    b = 65'd1;
    n = 0;
    lim = 65'd1 << width;
    for (int i = 0; i < 96; i++) begin
      if (b < lim) begin
        t = a + b;
        a = b;
        b = t;
        n = n + 1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/fib_job_scheduler_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr, wrapping. Purely combinational (0 cycles).
// No backpressure; the caller decides when a grant is taken.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       any
);

  localparam int IDW = $clog2(NUM_REQ);

  // k is the distance from ptr; the lowest distance with a live request wins.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!any && req[i] &&
            ((int'(ptr) + k == i) || (int'(ptr) + k == i + NUM_REQ))) begin
          any      = 1'b1;
          grant[i] = 1'b1;
          grant_id = IDW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/fib_job_scheduler.sv
// Shares one Fibonacci generator among NUM_REQ requesters; round-robin, one job at a time, 2-cycle minimum per shortcut job.
// Response is held until rsp_ready; FIB_SCHED_TIMEOUT_EN adds a WAIT-state watchdog of TIMEOUT cycles.
module fib_job_scheduler
  import fib_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int N_WIDTH = 8,
  parameter int MAX_N   = 13,
  parameter int TIMEOUT = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*N_WIDTH-1:0]   req_n,
  output logic [NUM_REQ-1:0]           req_ack,
  output logic                         gen_start,
  output logic [N_WIDTH-1:0]           gen_n,
  input  logic [WIDTH-1:0]             gen_fib,
  input  logic                         gen_done,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic [WIDTH-1:0]             rsp_fib,
  output logic                         rsp_err,
  output logic                         busy
);

  localparam int IDW = $clog2(NUM_REQ);
  // Never trust MAX_N beyond what actually fits in WIDTH bits.
  localparam int N_LIMIT = (MAX_N < fib_max_n(WIDTH)) ? MAX_N : fib_max_n(WIDTH);
  localparam logic [N_WIDTH-1:0] N_LIMIT_V = N_WIDTH'(N_LIMIT);

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("fib_job_scheduler: TIMEOUT must be at least 2");
  end

  state_t             state;
  logic [IDW-1:0]     ptr;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IDW-1:0]     arb_id;
  logic               arb_any;
  logic [N_WIDTH-1:0] n_sel;

`ifdef FIB_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);
  logic [TW-1:0] wait_cnt;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req      (req),
    .ptr      (ptr),
    .grant    (arb_grant),
    .grant_id (arb_id),
    .any      (arb_any)
  );

  always_comb begin
    n_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) n_sel = req_n[i*N_WIDTH +: N_WIDTH];
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      req_ack   <= '0;
      gen_start <= 1'b0;
      gen_n     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_fib   <= '0;
      rsp_err   <= 1'b0;
`ifdef FIB_SCHED_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      req_ack   <= '0;
      gen_start <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_any) begin
            req_ack <= arb_grant;
            rsp_id  <= arb_id;
            if (n_sel == '0) begin
              rsp_fib   <= '0;
              rsp_err   <= 1'b0;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else if (n_sel > N_LIMIT_V) begin
              rsp_fib   <= FIB_ERR_VALUE[WIDTH-1:0];
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              gen_start <= 1'b1;
              gen_n     <= n_sel;
              state     <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          gen_n <= '0;
          state <= WAIT;
`ifdef FIB_SCHED_TIMEOUT_EN
          // wait_cnt tracks cycles since gen_start: 1 in the first WAIT cycle.
          wait_cnt <= TW'(1);
`endif
        end
        WAIT: begin
          if (gen_done) begin
            rsp_fib   <= gen_fib;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
`ifdef FIB_SCHED_TIMEOUT_EN
          else if (wait_cnt == TW'(TIMEOUT - 1)) begin
            rsp_fib   <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ptr       <= (rsp_id == IDW'(NUM_REQ - 1)) ? '0 : rsp_id + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fib_job_scheduler.md
Name: fib_job_scheduler

Overview:
- Shares one external Fibonacci generator between NUM_REQ requesters.
- Arbitrates round-robin and launches one job at a time on the generator (start pulse plus index).
- Waits for generator completion, then returns the result with the requester ID over a valid/ready response channel.
- Screens out-of-range and trivial indices without using the generator.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- WIDTH, 8, width of the Fibonacci result.
- N_WIDTH, 8, width of the index n.
- MAX_N, 13, largest index whose F(n) fits in WIDTH bits (F(0)=0, F(1)=1; F(13)=233).
- TIMEOUT, 255, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset; also resets the generator.
- req  in  NUM_REQ  per-requester job request; held until acked.
- req_n  in  NUM_REQ*N_WIDTH  flattened indices; slice i belongs to req[i].
- req_ack  out  NUM_REQ  one-hot, one-cycle pulse when a job is accepted.
- gen_start  out  1  one-cycle launch pulse to the generator.
- gen_n  out  N_WIDTH  index to the generator; valid while gen_start is high.
- gen_fib  in  WIDTH  generator result.
- gen_done  in  1  generator completion pulse.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer ready.
- rsp_id  out  $clog2(NUM_REQ)  index of the requester being answered.
- rsp_fib  out  WIDTH  result.
- rsp_err  out  1  out-of-range (or timeout) flag.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, sync release): state IDLE, round-robin pointer 0.
- All outputs 0 during reset: req_ack, gen_start, gen_n, rsp_*, busy.
- Reset mid-job drops the job silently; no ack or response is produced.
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- IDLE, any req high: grant the first asserted req at or after the pointer, wrapping around. Register the grant ID and its req_n slice.
  - n==0: go to RESP with rsp_fib=0, rsp_err=0.
  - n>MAX_N: go to RESP with rsp_fib all ones, rsp_err=1.
  - Otherwise: go to LAUNCH.
- req_ack[grant] pulses during the first cycle after the grant edge (the LAUNCH cycle or the first RESP cycle).
- LAUNCH:
  - gen_start=1 and gen_n=latched n for exactly one cycle; then go to WAIT.
  - gen_done in this cycle is ignored.
- WAIT:
  - On gen_done, capture gen_fib into rsp_fib with rsp_err=0, then go to RESP.
  - The response appears the cycle after gen_done.
- RESP:
  - rsp_valid, rsp_id, rsp_fib and rsp_err stay stable until rsp_valid&&rsp_ready.
  - On that handshake: pointer=grant+1 mod NUM_REQ, go to IDLE.
  - gen_done outside WAIT is ignored.
- Dropping req before ack withdraws the request. Requests arriving while busy wait; no queueing.
- Back-to-back: the next grant can occur in the IDLE cycle right after the handshake. Minimum turnaround is 2 cycles per job for the shortcut paths.
- Fairness: a continuously requesting requester is served within NUM_REQ jobs.

Optional Feature:
- FIB_SCHED_TIMEOUT_EN defined: a counter runs in WAIT.
  - After TIMEOUT cycles without gen_done: go to RESP with rsp_err=1, rsp_fib=0.
  - A late gen_done is ignored.
- Undefined: WAIT has no watchdog and waits indefinitely for gen_done.

Decomposition:
- Package fib_sched_pkg holds:
  - the state enum (IDLE, LAUNCH, WAIT, RESP);
  - the FIB_ERR_VALUE constant (all ones);
  - a function computing MAX_N for a given WIDTH, used as a consistency check.
- Sub-module rr_arbiter (parameter NUM_REQ):
  - inputs: req vector, pointer;
  - outputs: one-hot grant, encoded grant ID, any.
  - Combinational only.

Test Plan:
- req=0001, n0=10, generator returns 55 after 10 cycles, rsp_ready=1 → ack[0] and gen_start with gen_n=10 in the same cycle; rsp_valid with rsp_id=0, rsp_fib=55, rsp_err=0 one cycle after gen_done.
- req=1111 held continuously, all n=5 → grant order 0,1,2,3,0; every rsp_fib=5.
- n2=0 → no gen_start; rsp_fib=0 with rsp_id=2. n1=14 → no gen_start; rsp_err=1, rsp_fib=8'hFF.
- rsp_ready low for 6 cycles → rsp_* stable throughout, no new ack; the next grant follows the handshake.
- Assert rst during WAIT → all outputs 0 asynchronously; after release a fresh req=0010 is granted normally (pointer 0).
- With FIB_SCHED_TIMEOUT_EN and TIMEOUT=20, generator never sends done → rsp_err=1, rsp_fib=0 20 cycles after gen_start; a later gen_done is ignored.
